// File: rtl/fetch_stage.sv
// Instruction fetch stage: a FETCH/WAIT request FSM with at most one memory
// request in flight, a small in-order instruction buffer toward decode, and
// redirect handling that flushes the buffer and drops the in-flight response.
// Build option: define FETCH_SKID_EN for a two-entry buffer. Without it the
// buffer holds one entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        ImemReqValid,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemReqReady,
    input  logic        ImemRespValid,
    input  logic [31:0] ImemRespData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instruction,
    output logic [31:0] NextInstruct,
    input  logic        Redirect,
    input  logic [1:0]  RedirectKind,
    input  logic [31:0] RedirectBase,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] JumpReg
);

`ifdef FETCH_SKID_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        stale_q, stale_d;
    logic        run_q, run_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_next_q, head_next_d;
`ifdef FETCH_SKID_EN
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_next_q, tail_next_d;
`endif

    logic        pop;
    logic        push;
    logic        req_fire;
    logic        resp_fire;
    logic        outstanding_next;
    logic [1:0]  count_after_pop;
    logic [31:0] target;

    // The request is gated on room after this cycle's pop, so a full buffer
    // that is being drained can still issue the next fetch.
    assign OutValid        = (count_q != 2'd0);
    assign pop             = OutValid & OutReady;
    assign count_after_pop = count_q - {1'b0, pop};
    assign ImemReqValid    = run_q & (state_q == ST_FETCH) & (count_after_pop < DEPTH);
    assign ImemReqAddr     = pc_q;
    assign req_fire        = ImemReqValid & ImemReqReady;
    assign resp_fire       = (state_q == ST_WAIT) & ImemRespValid;
    assign push            = resp_fire & ~stale_q & ~Redirect;
    assign Instruction     = head_instr_q;
    assign NextInstruct    = head_next_q;

    // Redirect target; reserved kind 3 behaves as jump-register.
    always_comb begin
        target = JumpReg & 32'hFFFF_FFFC;
        case (RedirectKind)
            2'd0:    target = (RedirectBase + (BranchOffset << 2)) & 32'hFFFF_FFFC;
            2'd1:    target = {RedirectBase[31:28], JumpTarget, 2'b00};
            default: target = JumpReg & 32'hFFFF_FFFC;
        endcase
    end

    // FSM, PC and stale tracking; a redirect overrides the PC + 4 of a same-cycle handshake.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        stale_d          = stale_q;
        run_d            = 1'b1;
        outstanding_next = ((state_q == ST_WAIT) & ~ImemRespValid) | req_fire;
        if (req_fire) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + 32'd4;
        end
        if (resp_fire) begin
            state_d = ST_FETCH;
            stale_d = 1'b0;
        end
        if (Redirect) begin
            pc_d = target;
            if (outstanding_next) begin
                stale_d = 1'b1;
            end
        end
    end

    // In-order buffer: pop first, then push into the first free slot, then flush on redirect.
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_next_d  = head_next_q;
`ifdef FETCH_SKID_EN
        tail_instr_d = tail_instr_q;
        tail_next_d  = tail_next_q;
        if (pop) begin
            head_instr_d = tail_instr_q;
            head_next_d  = tail_next_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                head_instr_d = ImemRespData;
                head_next_d  = pc_q;
            end else begin
                tail_instr_d = ImemRespData;
                tail_next_d  = pc_q;
            end
        end
`else
        if (push) begin
            head_instr_d = ImemRespData;
            head_next_d  = pc_q;
        end
`endif
        count_d = count_after_pop + {1'b0, push};
        if (Redirect) begin
            count_d = 2'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            stale_q      <= 1'b0;
            run_q        <= 1'b0;
            count_q      <= 2'd0;
            head_instr_q <= 32'd0;
            head_next_q  <= 32'd0;
`ifdef FETCH_SKID_EN
            tail_instr_q <= 32'd0;
            tail_next_q  <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            run_q        <= run_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_next_q  <= head_next_d;
`ifdef FETCH_SKID_EN
            tail_instr_q <= tail_instr_d;
            tail_next_q  <= tail_next_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a queue-based reference model predicts the
// outputs every cycle, a simple memory model answers fetch requests, and
// directed sequences pin the model with hand-computed values.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemReqReady;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
    logic        Redirect;
    logic [1:0]  RedirectKind;
    logic [31:0] RedirectBase;
    logic [31:0] BranchOffset;
    logic [25:0] JumpTarget;
    logic [31:0] JumpReg;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .Clk(Clk), .Reset(Reset),
        .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
        .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
        .OutValid(OutValid), .OutReady(OutReady),
        .Instruction(Instruction), .NextInstruct(NextInstruct),
        .Redirect(Redirect), .RedirectKind(RedirectKind), .RedirectBase(RedirectBase),
        .BranchOffset(BranchOffset), .JumpTarget(JumpTarget), .JumpReg(JumpReg)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] next;
    } entry_t;

    int checks = 0;
    int failures = 0;
    int cycleNo = 0;

    // reference model state
    entry_t      mBuf[$];
    logic [31:0] mPc;
    logic [31:0] mReqAddr;
    bit          mOut, mStale, mStarted;
    bit          expReqValid;

    // memory model state
    bit          memPending;
    logic [31:0] memAddr;
    int          memDue;
    bit          memHold = 1'b0;
    bit          memRandom = 1'b0;
    bit          useFixed = 1'b0;
    logic [31:0] fixedData = 32'h0;

    // values sampled just before the active edge
    bit          sReqFire;
    logic [31:0] sReqAddr;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] targetOf(input logic [1:0] kind, input logic [31:0] base,
                                             input logic [31:0] off, input logic [25:0] jt,
                                             input logic [31:0] jr);
        logic [31:0] t;
        case (kind)
            2'd0:    t = base + off * 32'd4;
            2'd1:    t = {base[31:28], jt, 2'b00};
            default: t = {jr[31:2], 2'b00};
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task automatic modelReset();
        mBuf.delete();
        mPc        = RESET_PC;
        mOut       = 1'b0;
        mStale     = 1'b0;
        mStarted   = 1'b0;
        memPending = 1'b0;
    endtask

    // Compare the DUT outputs against the model's prediction for this cycle.
    task automatic checkOutput();
        bit pops;
        expReqValid = 1'b0;
        pops = (mBuf.size() != 0) && OutReady;
        expReqValid = mStarted && !mOut && ((mBuf.size() - int'(pops)) < DEPTH);
        chk("req_valid", {31'd0, ImemReqValid}, {31'd0, expReqValid});
        if (expReqValid) chk("req_addr", ImemReqAddr, mPc);
        chk("out_valid", {31'd0, OutValid}, {31'd0, mBuf.size() != 0});
        if (mBuf.size() != 0) begin
            chk("instruction", Instruction, mBuf[0].instr);
            chk("next_instruct", NextInstruct, mBuf[0].next);
        end
        sReqFire = ImemReqValid && ImemReqReady;
        sReqAddr = ImemReqAddr;
    endtask

    task automatic applyStimulus(input bit memRdy, input bit outRdy, input bit redir,
                                 input logic [1:0] kind, input logic [31:0] base,
                                 input logic [31:0] off, input logic [25:0] jt,
                                 input logic [31:0] jr);
        @(negedge Clk);
        ImemReqReady = memRdy;
        OutReady     = outRdy;
        Redirect     = redir;
        RedirectKind = kind;
        RedirectBase = base;
        BranchOffset = off;
        JumpTarget   = jt;
        JumpReg      = jr;
        if (memPending && !memHold && cycleNo >= memDue &&
            (!memRandom || $urandom_range(0, 3) != 0)) begin
            ImemRespValid = 1'b1;
            ImemRespData  = useFixed ? fixedData : memData(memAddr);
        end else begin
            ImemRespValid = 1'b0;
            ImemRespData  = $urandom;
        end
        #1;
        checkOutput();
    endtask

    // Advance the model and memory across the active edge.
    task automatic advanceClock();
        bit pop;
        @(posedge Clk);
        cycleNo++;
        if (!Reset) begin
            modelReset();
            return;
        end
        pop = (mBuf.size() != 0) && OutReady;
        if (ImemRespValid) memPending = 1'b0;
        if (sReqFire) begin
            memPending = 1'b1;
            memAddr    = sReqAddr;
            memDue     = cycleNo + (memRandom ? $urandom_range(0, 2) : 0);
        end
        if (pop) void'(mBuf.pop_front());
        if (ImemRespValid && mOut) begin
            if (!mStale && !Redirect) mBuf.push_back({ImemRespData, mReqAddr + 32'd4});
            mOut   = 1'b0;
            mStale = 1'b0;
        end
        if (expReqValid && ImemReqReady) begin
            mOut     = 1'b1;
            mReqAddr = mPc;
            mPc      = mPc + 32'd4;
        end
        if (Redirect) begin
            mBuf.delete();
            mPc = targetOf(RedirectKind, RedirectBase, BranchOffset, JumpTarget, JumpReg);
            if (mOut) mStale = 1'b1;
        end
        mStarted = 1'b1;
    endtask

    task automatic step(input bit memRdy, input bit outRdy);
        applyStimulus(memRdy, outRdy, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        advanceClock();
    endtask

    // Wait (bounded) for the next request and compare its address.
    task automatic expectRequest(input string name, input logic [31:0] addr);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
            if (ImemReqValid) begin
                chk(name, ImemReqAddr, addr);
                found = 1'b1;
            end
            advanceClock();
        end
        chk({name, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic redirectAndExpect(input string name, input logic [1:0] kind,
                                     input logic [31:0] base, input logic [31:0] off,
                                     input logic [25:0] jt, input logic [31:0] jr,
                                     input logic [31:0] addr);
        applyStimulus(1'b1, 1'b1, 1'b1, kind, base, off, jt, jr);
        advanceClock();
        expectRequest(name, addr);
    endtask

    task automatic releaseReset();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        chk("req_valid_first_cycle", {31'd0, ImemReqValid}, 32'd0);
        advanceClock();
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, ImemReqValid}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, OutValid}, 32'd0);
        chk({tag, "_instruction"}, Instruction, 32'd0);
        chk({tag, "_next_instruct"}, NextInstruct, 32'd0);
        chk({tag, "_req_addr"}, ImemReqAddr, RESET_PC);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        bit prevRedir;
        logic [31:0] r;
        logic [15:0] imm;

        Reset = 1'b0;
        ImemReqReady = 1'b0; ImemRespValid = 1'b0; ImemRespData = 32'd0;
        OutReady = 1'b0; Redirect = 1'b0; RedirectKind = 2'd0;
        RedirectBase = 32'd0; BranchOffset = 32'd0; JumpTarget = 26'd0; JumpReg = 32'd0;
        modelReset();

        // Reset values
        @(negedge Clk);
        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge Clk);

        // First fetch with single-cycle memory and a fixed instruction word
        useFixed  = 1'b1;
        fixedData = 32'h2008_0005;
        releaseReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        chk("first_req_addr", ImemReqAddr, 32'h0);
        advanceClock();
        step(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        chk("first_instruction", Instruction, 32'h2008_0005);
        chk("first_next_instruct", NextInstruct, 32'h4);
        chk("second_req_addr", ImemReqAddr, 32'h4);
        advanceClock();
        useFixed = 1'b0;

        // Decode stalls: buffer fills to its depth and requests stop
        repeat (8) step(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        chk("stall_req_valid", {31'd0, ImemReqValid}, 32'd0);
        chk("stall_head_instr", Instruction, memData(32'h4));
        chk("stall_head_next", NextInstruct, 32'h8);
        advanceClock();
        step(1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
            if (OutValid) begin
                chk("stall_second_next", NextInstruct, 32'hC);
                found = 1'b1;
            end
            advanceClock();
        end
        chk("stall_second_seen", {31'd0, found}, 32'd1);

        // Branch while a request is outstanding
        memHold = 1'b1;
        for (int i = 0; i < 10 && !mOut; i++) step(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'h40, 32'hFFFF_FFFE, 26'd0, 32'd0);
        advanceClock();
        memHold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
            if (ImemReqValid) begin
                chk("branch_req_addr", ImemReqAddr, 32'h38);
                chk("branch_out_valid", {31'd0, OutValid}, 32'd0);
                found = 1'b1;
            end
            advanceClock();
        end
        chk("branch_req_seen", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
            if (OutValid) begin
                chk("branch_instr", Instruction, memData(32'h38));
                chk("branch_next", NextInstruct, 32'h3C);
                found = 1'b1;
            end
            advanceClock();
        end
        chk("branch_data_seen", {31'd0, found}, 32'd1);

        // Jump, jump-register, reserved kind and PC wrap
        redirectAndExpect("jump_addr", 2'd1, 32'hA000_0010, 32'd0, 26'h000_0100, 32'd0, 32'hA000_0400);
        redirectAndExpect("jr_addr", 2'd2, 32'd0, 32'd0, 26'd0, 32'h0000_1003, 32'h0000_1000);
        redirectAndExpect("reserved_addr", 2'd3, 32'd0, 32'd0, 26'd0, 32'h0000_2007, 32'h0000_2004);
        redirectAndExpect("wrap_addr", 2'd2, 32'd0, 32'd0, 26'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        expectRequest("wrap_next_addr", 32'h0);

        // Redirect together with a response and a pop
        for (int i = 0; i < 8 && mBuf.size() == 0; i++) step(1'b1, 1'b0);
        memHold = 1'b1;
        for (int i = 0; i < 6 && !mOut; i++) step(1'b1, 1'b0);
        memHold = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 32'd0, 32'd0, 26'd0, 32'h0000_0100);
        advanceClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        chk("flush_out_valid", {31'd0, OutValid}, 32'd0);
        advanceClock();
        expectRequest("flush_req_addr", 32'h100);

        // Randomized traffic against the model
        memRandom = 1'b1;
        prevRedir = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit redir;
            redir = !prevRedir && ($urandom_range(0, 11) == 0);
            r   = $urandom;
            imm = 16'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, redir,
                          2'($urandom_range(0, 3)), r & 32'hFFFF_FFFC,
                          {{16{imm[15]}}, imm}, 26'($urandom), $urandom);
            advanceClock();
            prevRedir = redir;
        end
        memRandom = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

        // Asynchronous reset while waiting on memory
        memHold = 1'b1;
        for (int i = 0; i < 10 && !mOut; i++) step(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 26'd0, 32'd0);
        #2;
        Reset = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        advanceClock();
        repeat (2) @(posedge Clk);
        memHold = 1'b0;
        releaseReset();
        expectRequest("post_reset_addr", RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
